// File: rtl/irq_controller_if.sv
// Bus bundle for irq_controller.
//   irq_sources  : raw level interrupt lines (asynchronous to the clock)
//   reset_irq    : one-cycle acknowledge that retires the in-service interrupt
//   irq/irq_addr : registered request and handler address to the control path
//   reg_*        : memory-mapped register-file port (combinational read)
// master = the system side (peripherals + control path + software),
// slave  = the controller itself.
interface irq_controller_if #(
  parameter int NUM_SOURCES = 8
);
  logic [NUM_SOURCES-1:0] irq_sources;
  logic                   reset_irq;
  logic                   irq;
  logic [15:0]            irq_addr;
  logic                   reg_write_en;
  logic [1:0]             reg_addr;
  logic [15:0]            reg_wdata;
  logic [15:0]            reg_rdata;

  modport master (
    output irq_sources, reset_irq, reg_write_en, reg_addr, reg_wdata,
    input  irq, irq_addr, reg_rdata
  );

  modport slave (
    input  irq_sources, reset_irq, reg_write_en, reg_addr, reg_wdata,
    output irq, irq_addr, reg_rdata
  );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: synchronises and edge-detects up to 16 interrupt lines,
// latches them as pending, gates them with a mask and a global enable and
// presents the lowest-numbered eligible source to the control path as a
// single registered request plus handler address.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : irq_controller_if.slave (sources, acknowledge, request, registers)
//
// Register map (bits at or above NUM_SOURCES read 0 and ignore writes):
//   0 MASK    RW   bit i enables source i
//   1 PENDING R/W1C
//   2 CTRL    RW   bit 0 global enable
//   3 STATUS  RO   bit 15 in_service, bits 3:0 active index
module irq_controller #(
  parameter int          NUM_SOURCES  = 8,
  parameter logic [15:0] VECTOR_BASE  = 16'hFF00,
  parameter int          VECTOR_SHIFT = 2
) (
  input logic          clock,
  input logic          reset,
  irq_controller_if.slave bus
);

  localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SOURCES) - 32'd1);

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVICE  = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_SOURCES-1:0] sync1_q, sync1_d;
  logic [NUM_SOURCES-1:0] sync2_q, sync2_d;
  logic [NUM_SOURCES-1:0] prev_q, prev_d;
  logic [15:0]            pending_q, pending_d;
  logic [15:0]            mask_q, mask_d;
  logic                   enable_q, enable_d;
  logic [3:0]             active_q, active_d;
  logic                   irq_q, irq_d;
  logic [15:0]            irq_addr_q, irq_addr_d;

  logic [15:0]            edge_vec;
  logic [15:0]            request;
  logic [15:0]            w1c_clr;
  logic [15:0]            retire_clr;
  logic                   wr_mask, wr_pend, wr_ctrl;
  logic                   retire;

  // Handler address wraps modulo 2^16 by construction of the 16-bit sum.
  function automatic logic [15:0] vector_addr(input logic [3:0] idx);
    return VECTOR_BASE + ({12'd0, idx} << VECTOR_SHIFT);
  endfunction

  // Fixed priority: the lowest set index wins.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Synchroniser, edge detect and register-file next state.
  always_comb begin
    sync1_d  = bus.irq_sources;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    edge_vec = 16'(sync2_q & ~prev_q);

    wr_mask = bus.reg_write_en && (bus.reg_addr == ADDR_MASK);
    wr_pend = bus.reg_write_en && (bus.reg_addr == ADDR_PENDING);
    wr_ctrl = bus.reg_write_en && (bus.reg_addr == ADDR_CTRL);

    retire     = (state_q == SERVICE) && bus.reset_irq;
    retire_clr = retire ? (16'd1 << active_q) : 16'd0;
    w1c_clr    = wr_pend ? bus.reg_wdata : 16'd0;

    // A fresh edge wins over any clear landing in the same cycle.
    pending_d = ((pending_q & ~w1c_clr & ~retire_clr) | edge_vec) & SRC_MASK;
    mask_d    = wr_mask ? (bus.reg_wdata & SRC_MASK) : mask_q;
    enable_d  = wr_ctrl ? bus.reg_wdata[0] : enable_q;
  end

  // Arbitration FSM next state; arbitration sees the registered mask and
  // enable, so a write takes part in arbitration from the following cycle.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    irq_d      = irq_q;
    irq_addr_d = irq_addr_q;
    request    = enable_q ? (pending_q & mask_q) : 16'd0;

    unique case (state_q)
      IDLE: begin
        irq_d = 1'b0;
        if (request != 16'd0) begin
          active_d   = lowest_set(request);
          irq_addr_d = vector_addr(lowest_set(request));
          irq_d      = 1'b1;
          state_d    = SERVICE;
        end
      end
      SERVICE: begin
        // Active index and address are frozen until the acknowledge.
        if (bus.reset_irq) begin
          irq_d   = 1'b0;
          state_d = COOLDOWN;
        end
      end
      COOLDOWN: begin
        // One guaranteed low cycle between consecutive requests.
        irq_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      pending_q  <= 16'd0;
      mask_q     <= 16'd0;
      enable_q   <= 1'b0;
      state_q    <= IDLE;
      active_q   <= 4'd0;
      irq_q      <= 1'b0;
      irq_addr_q <= 16'd0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      enable_q   <= enable_d;
      state_q    <= state_d;
      active_q   <= active_d;
      irq_q      <= irq_d;
      irq_addr_q <= irq_addr_d;
    end
  end

  // Combinational register read; irq_q doubles as the in_service flag
  // because it is high exactly while the FSM sits in SERVICE.
  always_comb begin
    bus.reg_rdata = 16'd0;
    unique case (bus.reg_addr)
      ADDR_MASK:    bus.reg_rdata = mask_q;
      ADDR_PENDING: bus.reg_rdata = pending_q;
      ADDR_CTRL:    bus.reg_rdata = {15'd0, enable_q};
      ADDR_STATUS:  bus.reg_rdata = {irq_q, 11'd0, active_q};
      default:      bus.reg_rdata = 16'd0;
    endcase
  end

  assign bus.irq      = irq_q;
  assign bus.irq_addr = irq_addr_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios with constant expectations,
// then randomized traffic compared against a sample-history reference model.
module tb_irq_controller;
  localparam int NS = 8;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  irq_controller_if #(.NUM_SOURCES(NS)) bus ();

  irq_controller #(
    .NUM_SOURCES (NS),
    .VECTOR_BASE (16'hFF00),
    .VECTOR_SHIFT(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: raw samples taken at each clock edge (newest first);
  // an edge is recognised two samples after the line was first seen high.
  logic [7:0]  samp[$];
  logic [7:0]  m_pend;
  logic [7:0]  m_mask;
  logic        m_en;
  int          m_mode;   // 0 idle, 1 serving, 2 cooldown
  logic [3:0]  m_active;
  logic [15:0] m_addr;

  function automatic void model_reset();
    samp     = {8'h00, 8'h00, 8'h00, 8'h00};
    m_pend   = 8'h00;
    m_mask   = 8'h00;
    m_en     = 1'b0;
    m_mode   = 0;
    m_active = 4'd0;
    m_addr   = 16'h0000;
  endfunction

  function automatic void model_step(input logic [7:0] src, input logic ack,
                                     input logic we, input logic [1:0] a,
                                     input logic [15:0] wd);
    logic [7:0] edges, req, clr;
    samp.push_front(src);
    while (samp.size() > 4) void'(samp.pop_back());
    edges = samp[2] & ~samp[3];
    req   = m_en ? (m_pend & m_mask) : 8'h00;
    clr   = 8'h00;
    if (m_mode == 0) begin
      for (int i = 0; i < NS; i++) begin
        if (req[i]) begin
          m_active = 4'(i);
          m_addr   = 16'hFF00 + 16'(i * 4);
          m_mode   = 1;
          break;
        end
      end
    end else if (m_mode == 1) begin
      if (ack) begin
        clr    = 8'(1 << m_active);
        m_mode = 2;
      end
    end else begin
      m_mode = 0;
    end
    if (we && a == 2'd1) clr = clr | wd[7:0];
    m_pend = (m_pend & ~clr) | edges;
    if (we && a == 2'd0) m_mask = wd[7:0];
    if (we && a == 2'd2) m_en = wd[0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    model_step(bus.irq_sources, bus.reset_irq, bus.reg_write_en, bus.reg_addr, bus.reg_wdata);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.reg_write_en = 1'b1;
    bus.reg_addr     = a;
    bus.reg_wdata    = d;
    tick();
    bus.reg_write_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    bus.reg_addr = a;
    #1;
    d = bus.reg_rdata;
  endtask

  task automatic pulse_src(input logic [7:0] bits);
    bus.irq_sources = bits;
    tick();
    bus.irq_sources = 8'h00;
  endtask

  task automatic ack();
    bus.reset_irq = 1'b1;
    tick();
    bus.reset_irq = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %0b want 0", bus.irq);
    end
    vectors++;
    if (bus.irq_addr !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_addr: got %h want 0000", bus.irq_addr);
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      vectors++;
      if (d !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got %h want 0000", a, d);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic [15:0] d;
    wr(2'd0, 16'h0004);
    wr(2'd2, 16'h0001);
    pulse_src(8'h04);
    tick();
    tick();
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early: irq got %0b want 0 at k+2", bus.irq);
    end
    rd(2'd1, d);
    vectors++;
    if (d !== 16'h0004) begin
      miscompares++;
      $display("FAIL basic_pending: got %h want 0004", d);
    end
    tick();
    vectors++;
    if (bus.irq !== 1'b1 || bus.irq_addr !== 16'hFF08) begin
      miscompares++;
      $display("FAIL basic_irq: got irq=%0b addr=%h want 1/ff08", bus.irq, bus.irq_addr);
    end
    rd(2'd3, d);
    vectors++;
    if (d !== 16'h8002) begin
      miscompares++;
      $display("FAIL basic_status: got %h want 8002", d);
    end
    ack();
    rd(2'd1, d);
    vectors++;
    if (bus.irq !== 1'b0 || d !== 16'h0000) begin
      miscompares++;
      $display("FAIL basic_retire: got irq=%0b pend=%h want 0/0000", bus.irq, d);
    end
    tick();
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_cooldown: irq got %0b want 0", bus.irq);
    end
    tick();
  endtask

  task automatic test_priority();
    logic [15:0] d;
    wr(2'd0, 16'h00FF);
    pulse_src(8'h22);
    repeat (3) tick();
    vectors++;
    if (bus.irq !== 1'b1 || bus.irq_addr !== 16'hFF04) begin
      miscompares++;
      $display("FAIL prio_first: got irq=%0b addr=%h want 1/ff04", bus.irq, bus.irq_addr);
    end
    ack();
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_drop: irq got %0b want 0", bus.irq);
    end
    tick();
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_cooldown: irq got %0b want 0", bus.irq);
    end
    tick();
    vectors++;
    if (bus.irq !== 1'b1 || bus.irq_addr !== 16'hFF14) begin
      miscompares++;
      $display("FAIL prio_second: got irq=%0b addr=%h want 1/ff14", bus.irq, bus.irq_addr);
    end
    ack();
    tick();
    tick();
    rd(2'd1, d);
    vectors++;
    if (d !== 16'h0000 || bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_end: got pend=%h irq=%0b want 0000/0", d, bus.irq);
    end
  endtask

  task automatic test_mask_gate();
    logic [15:0] d;
    wr(2'd2, 16'h0000);
    wr(2'd0, 16'h0000);
    pulse_src(8'h08);
    repeat (3) tick();
    rd(2'd1, d);
    vectors++;
    if (d !== 16'h0008 || bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL gate_pending: got pend=%h irq=%0b want 0008/0", d, bus.irq);
    end
    wr(2'd0, 16'h0008);
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL gate_disabled: irq got %0b want 0", bus.irq);
    end
    wr(2'd2, 16'h0001);
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL gate_same_cycle: irq got %0b want 0", bus.irq);
    end
    tick();
    vectors++;
    if (bus.irq !== 1'b1 || bus.irq_addr !== 16'hFF0C) begin
      miscompares++;
      $display("FAIL gate_enable: got irq=%0b addr=%h want 1/ff0c", bus.irq, bus.irq_addr);
    end
    ack();
    tick();
    tick();
  endtask

  task automatic test_service_hold();
    logic [15:0] d;
    wr(2'd0, 16'h0001);
    pulse_src(8'h01);
    repeat (3) tick();
    vectors++;
    if (bus.irq !== 1'b1 || bus.irq_addr !== 16'hFF00) begin
      miscompares++;
      $display("FAIL hold_start: got irq=%0b addr=%h want 1/ff00", bus.irq, bus.irq_addr);
    end
    wr(2'd0, 16'h0000);
    wr(2'd1, 16'h0001);
    rd(2'd1, d);
    vectors++;
    if (d !== 16'h0000) begin
      miscompares++;
      $display("FAIL hold_w1c: pend got %h want 0000", d);
    end
    tick();
    tick();
    vectors++;
    if (bus.irq !== 1'b1 || bus.irq_addr !== 16'hFF00) begin
      miscompares++;
      $display("FAIL hold_stable: got irq=%0b addr=%h want 1/ff00", bus.irq, bus.irq_addr);
    end
    ack();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.irq !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_after_%0d: irq got %0b want 0", i, bus.irq);
      end
      tick();
    end
  endtask

  task automatic test_w1c_race();
    logic [15:0] d;
    pulse_src(8'h10);
    repeat (3) tick();
    rd(2'd1, d);
    vectors++;
    if (d !== 16'h0010) begin
      miscompares++;
      $display("FAIL race_setup: pend got %h want 0010", d);
    end
    pulse_src(8'h10);
    tick();
    wr(2'd1, 16'h0010);
    rd(2'd1, d);
    vectors++;
    if (d !== 16'h0010) begin
      miscompares++;
      $display("FAIL race_set_wins: pend got %h want 0010", d);
    end
    wr(2'd1, 16'hFFFF);
    rd(2'd1, d);
    vectors++;
    if (d !== 16'h0000) begin
      miscompares++;
      $display("FAIL race_plain_w1c: pend got %h want 0000", d);
    end
  endtask

  task automatic test_reset_mid_service();
    logic [15:0] d;
    wr(2'd0, 16'h0001);
    wr(2'd2, 16'h0001);
    pulse_src(8'h01);
    repeat (3) tick();
    vectors++;
    if (bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: irq got %0b want 1", bus.irq);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.irq !== 1'b0 || bus.irq_addr !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_async: got irq=%0b addr=%h want 0/0000", bus.irq, bus.irq_addr);
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      vectors++;
      if (d !== 16'h0000) begin
        miscompares++;
        $display("FAIL rst_reg%0d: got %h want 0000", a, d);
      end
    end
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      ack();
      rd(2'd3, d);
      vectors++;
      if (bus.irq !== 1'b0 || d !== 16'h0000) begin
        miscompares++;
        $display("FAIL idle_ack_%0d: got irq=%0b status=%h want 0/0000", i, bus.irq, d);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [15:0] wd;
    logic [7:0]  s;
    wr(2'd2, 16'h0001);
    wr(2'd0, 16'h00FF);
    for (int c = 0; c < 1500; c++) begin
      s = bus.irq_sources;
      for (int b = 0; b < NS; b++) begin
        if ($urandom_range(0, 7) == 0) s[b] = ~s[b];
      end
      bus.irq_sources  = s;
      bus.reset_irq    = ($urandom_range(0, 3) == 0);
      bus.reg_write_en = ($urandom_range(0, 5) == 0);
      bus.reg_addr     = 2'($urandom_range(0, 3));
      wd               = 16'($urandom);
      if (bus.reg_addr == 2'd1) wd = 16'd1 << $urandom_range(0, 15);
      if (bus.reg_addr == 2'd2) wd[0] = ($urandom_range(0, 7) != 0);
      bus.reg_wdata = wd;
      tick();
      bus.reg_write_en = 1'b0;
      bus.reset_irq    = 1'b0;
      vectors++;
      if (bus.irq !== (m_mode == 1) || bus.irq_addr !== m_addr) begin
        miscompares++;
        $display("FAIL rand_irq c=%0d: got %0b/%h want %0b/%h", c, bus.irq, bus.irq_addr,
                 (m_mode == 1), m_addr);
      end
      rd(2'd1, d);
      vectors++;
      if (d !== {8'h00, m_pend}) begin
        miscompares++;
        $display("FAIL rand_pending c=%0d: got %h want %h", c, d, {8'h00, m_pend});
      end
      rd(2'd0, d);
      vectors++;
      if (d !== {8'h00, m_mask}) begin
        miscompares++;
        $display("FAIL rand_mask c=%0d: got %h want %h", c, d, {8'h00, m_mask});
      end
      rd(2'd2, d);
      vectors++;
      if (d !== {15'd0, m_en}) begin
        miscompares++;
        $display("FAIL rand_ctrl c=%0d: got %h want %h", c, d, {15'd0, m_en});
      end
      rd(2'd3, d);
      vectors++;
      if (d !== {(m_mode == 1), 11'd0, m_active}) begin
        miscompares++;
        $display("FAIL rand_status c=%0d: got %h want %h", c, d,
                 {(m_mode == 1), 11'd0, m_active});
      end
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    bus.irq_sources  = 8'h00;
    bus.reset_irq    = 1'b0;
    bus.reg_write_en = 1'b0;
    bus.reg_addr     = 2'd0;
    bus.reg_wdata    = 16'h0000;
    model_reset();
    test_reset();
    test_basic();
    test_priority();
    test_mask_gate();
    test_service_hold();
    test_w1c_race();
    test_reset_mid_service();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller upstream of the CPU control path. Synchronises and edge-detects up to 16 peripheral interrupt lines, latches them as pending, applies a software mask and global enable, and arbitrates by fixed priority. It presents one interrupt request and its 16-bit handler address to the control path. It retires the request when the control path pulses `reset_irq`. Software accesses a small register file through a memory-mapped port.

## Interface
- NUM_SOURCES, 8, number of interrupt lines (legal 1..16).
- VECTOR_BASE, 16'hFF00, handler address of source 0.
- VECTOR_SHIFT, 2, log2 spacing between consecutive handler addresses.

- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- irq_sources  input  NUM_SOURCES  raw level interrupt lines, asynchronous to `clock`; an interrupt is a rising edge.
- reset_irq  input  1  one-cycle acknowledge from the control path; retires the in-service interrupt.
- irq  output  1  registered interrupt request to the control path.
- irq_addr  output  16  registered handler address of the in-service interrupt; valid while `irq`=1.
- reg_write_en  input  1  register-file write strobe.
- reg_addr  input  2  register select.
- reg_wdata  input  16  write data.
- reg_rdata  output  16  combinational read data for `reg_addr`.

## Operation
- Per-source chain: two synchroniser flops, then a `prev` flop. An edge is detected when sync2=1 and prev=0.
  - The chain resets to 0, so a line held high through reset yields one edge after release.
- `pending[i]` is set by a detected edge on source i. It is cleared by a write-1-to-clear or by a retire of source i.
  - Set and clear in the same cycle: set wins.
- Registers (bits at or above NUM_SOURCES read 0 and ignore writes):
  - Address 0, MASK (RW). Bit i=1 enables source i.
  - Address 1, PENDING. Read returns `pending`. A write clears the bits written as 1.
  - Address 2, CTRL (RW). Bit 0 is the global enable; other bits read 0.
  - Address 3, STATUS (RO). Bit 15 = in_service, bits 3:0 = active index; other bits 0. Writes are ignored.
- FSM states:
  - IDLE: `irq`=0. If the global enable is 1 and (pending & MASK) is nonzero, latch the lowest set index as active, compute irq_addr = (VECTOR_BASE + (index << VECTOR_SHIFT)) mod 2^16, set `irq`=1, and go to SERVICE.
  - SERVICE: `irq`=1 and irq_addr is held stable. MASK, CTRL, PENDING writes and new edges do not change the active index or the address. On `reset_irq`=1: clear `pending[active]`, set `irq`=0, and go to COOLDOWN.
  - COOLDOWN: `irq`=0 for exactly one cycle, then go to IDLE. This guarantees the control path sees a deasserted line between consecutive interrupts.
- Edge cases:
  - `reset_irq` in IDLE or COOLDOWN is ignored.
  - A W1C of the active bit during SERVICE clears `pending` but does not cancel the in-service request.
  - A new edge on the active source during SERVICE: the retire clear and the set coincide, so set wins and the source re-arbitrates after COOLDOWN.
- Reset values: `irq`=0; irq_addr=0; MASK, PENDING, CTRL all 0; active index 0; in_service 0; FSM in IDLE.
  - Asserting reset mid-SERVICE drops `irq` immediately and asynchronously.

## Timing
- Source rising edge first sampled high at clock edge k:
  - sync2=1 after edge k+1.
  - `pending` set at edge k+2.
  - `irq`=1 and irq_addr valid at edge k+3, when enabled and idle.
- Writes take effect at the clock edge where `reg_write_en`=1. A MASK or enable change affects arbitration in the following cycle.
- `reset_irq` sampled at edge m: `irq`=0 after edge m; earliest re-assertion is after edge m+2.
- `reg_rdata` is combinational from the current register state, with no wait states.

## Test plan
- Enable on, MASK=8'h04, pulse source 2 high for 1 cycle at edge k.
  - Required: `irq`=1 with irq_addr=16'hFF08 after edge k+3.
  - Then pulse `reset_irq`: `irq`=0 for ≥1 cycle and PENDING reads 0.
- Edges on sources 5 and 1 in the same cycle, MASK=8'hFF.
  - Required: first irq_addr=16'hFF04. After retire plus cooldown, irq_addr=16'hFF14. PENDING reads 0 at the end.
- MASK=0 and source 3 edge.
  - Required: PENDING reads 16'h0008 and `irq` stays 0.
  - Then write MASK=8'h08 and CTRL=1: `irq`=1 on the next cycle with irq_addr=16'hFF0C.
- In SERVICE on source 0, write MASK=0 and W1C PENDING=16'h0001.
  - Required: `irq` and irq_addr=16'hFF00 unchanged until `reset_irq`, then `irq` stays 0.
- Same cycle: W1C of bit 4 and a detected edge on source 4.
  - Required: PENDING bit 4 reads 1.
- Assert reset while `irq`=1.
  - Required: `irq`=0 immediately and all registers read 0.
  - `reset_irq` pulses while idle leave the state unchanged.
